// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide sequencer: issues mult/div, holds HI/LO busy for a
// fixed latency, commits the pending result, and services mfhi/mflo/mthi/mtlo.
//
// state  | meaning
// IDLE   | no mult/div in flight; mthi/mtlo and new mult/div accepted
// BUSY   | mult/div in flight; cnt counts down to the commit edge
module e_mdu_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_Start,
  input  logic [3:0]  E_MDOp,
  input  logic [31:0] E_RS,
  input  logic [31:0] E_RT,
  input  logic        D_IsMD,
  output logic [31:0] E_MDOut,
  output logic        E_Busy,
  output logic        D_MDStall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0] MULT_TC = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_TC  = CNT_W'(DIV_LAT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [31:0]       hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
  logic              pend_q, pend_d;

  logic              is_long_op;
  logic              is_div_op;
  logic signed [63:0] prod_s;
  logic [63:0]       prod_u;
  logic              div_ovf;
  logic              div_zero;
  logic [31:0]       divisor;
  logic [31:0]       dividend;
  logic signed [31:0] quot_s, rem_s;
  logic [31:0]       quot_u, rem_u;
  logic [31:0]       res_hi, res_lo;
  logic              res_wr;

  assign is_long_op = (E_MDOp == OP_MULT) || (E_MDOp == OP_MULTU) ||
                      (E_MDOp == OP_DIV)  || (E_MDOp == OP_DIVU);
  assign is_div_op  = (E_MDOp == OP_DIV)  || (E_MDOp == OP_DIVU);

  assign prod_s = $signed({{32{E_RS[31]}}, E_RS}) * $signed({{32{E_RT[31]}}, E_RT});
  assign prod_u = {32'd0, E_RS} * {32'd0, E_RT};

  // Operands are sanitised so the dividers never see x/0 or the signed
  // overflow case; both are resolved explicitly in the result mux.
  assign div_zero = (E_RT == 32'd0);
  assign div_ovf  = (E_RS == 32'h8000_0000) && (E_RT == 32'hFFFF_FFFF);
  assign divisor  = div_zero ? 32'd1 : E_RT;
  assign dividend = div_ovf ? 32'd0 : E_RS;

  assign quot_s = $signed(dividend) / $signed(divisor);
  assign rem_s  = $signed(dividend) % $signed(divisor);
  assign quot_u = E_RS / divisor;
  assign rem_u  = E_RS % divisor;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_wr = 1'b0;
    case (E_MDOp)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
        res_wr = 1'b1;
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
        res_wr = 1'b1;
      end
      OP_DIV: begin
        res_hi = div_ovf ? 32'd0 : rem_s;
        res_lo = div_ovf ? 32'h8000_0000 : quot_s;
        res_wr = !div_zero;
      end
      OP_DIVU: begin
        res_hi = rem_u;
        res_lo = quot_u;
        res_wr = !div_zero;
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_wr = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      hi_tmp_q <= 32'd0;
      lo_tmp_q <= 32'd0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
      pend_q   <= pend_d;
    end
  end

  // Anything arriving while BUSY is dropped, including a new op on the commit edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    pend_d   = pend_q;
    case (state_q)
      S_IDLE: begin
        if (E_Start) begin
          if (is_long_op) begin
            hi_tmp_d = res_hi;
            lo_tmp_d = res_lo;
            pend_d   = res_wr;
            cnt_d    = is_div_op ? DIV_TC : MULT_TC;
            state_d  = S_BUSY;
          end else if (E_MDOp == OP_MTHI) begin
            hi_d = E_RS;
          end else if (E_MDOp == OP_MTLO) begin
            lo_d = E_RS;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (pend_q) begin
            hi_d = hi_tmp_q;
            lo_d = lo_tmp_q;
          end
          pend_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign E_Busy    = (state_q == S_BUSY);
  assign D_MDStall = D_IsMD & (E_Busy | (E_Start & is_long_op));
  assign E_MDOut   = (E_MDOp == OP_MFHI) ? hi_q :
                     (E_MDOp == OP_MFLO) ? lo_q : 32'd0;
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Directed bench for e_mdu_ctrl: latency, arithmetic, stall, move ops,
// ignored hazards and asynchronous reset mid-operation.
module tb_e_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic        E_Start;
  logic [3:0]  E_MDOp;
  logic [31:0] E_RS;
  logic [31:0] E_RT;
  logic        D_IsMD;
  logic [31:0] E_MDOut;
  logic        E_Busy;
  logic        D_MDStall;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;

  e_mdu_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .E_Start   (E_Start),
    .E_MDOp    (E_MDOp),
    .E_RS      (E_RS),
    .E_RT      (E_RT),
    .D_IsMD    (D_IsMD),
    .E_MDOut   (E_MDOut),
    .E_Busy    (E_Busy),
    .D_MDStall (D_MDStall),
    .HI        (HI),
    .LO        (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    E_Start = 1'b1;
    E_MDOp  = op;
    E_RS    = rs;
    E_RT    = rt;
  endtask

  task automatic idle();
    E_Start = 1'b0;
    E_MDOp  = 4'd0;
    E_RS    = 32'd0;
    E_RT    = 32'd0;
  endtask

  initial begin
    reset  = 1'b0;
    D_IsMD = 1'b0;
    idle();
    #2;
    chk("rst_busy", {31'd0, E_Busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_stall", {31'd0, D_MDStall}, 32'd0);
    tick();
    tick();
    reset = 1'b1;

    // 1: mult -1 * 2
    issue(4'd1, 32'hFFFF_FFFF, 32'd2);
    #1;
    chk("t1_busy_issue", {31'd0, E_Busy}, 32'd0);
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      chk("t1_busy", {31'd0, E_Busy}, 32'd1);
      chk("t1_hi_hold", HI, 32'd0);
      tick();
    end
    chk("t1_busy_done", {31'd0, E_Busy}, 32'd0);
    chk("t1_hi", HI, 32'hFFFF_FFFF);
    chk("t1_lo", LO, 32'hFFFF_FFFE);

    // 2: multu, non-MD in D never stalls
    issue(4'd2, 32'hFFFF_FFFF, 32'd2);
    tick();
    idle();
    D_IsMD = 1'b0;
    #1;
    chk("t2_nonmd_stall", {31'd0, D_MDStall}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t2_busy", {31'd0, E_Busy}, 32'd1);
      tick();
    end
    chk("t2_busy_done", {31'd0, E_Busy}, 32'd0);
    chk("t2_hi", HI, 32'h0000_0001);
    chk("t2_lo", LO, 32'hFFFF_FFFE);

    // 3: div -7/2, then divu 7/0
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    tick();
    idle();
    for (int i = 0; i < 10; i++) begin
      chk("t3_busy", {31'd0, E_Busy}, 32'd1);
      tick();
    end
    chk("t3_busy_done", {31'd0, E_Busy}, 32'd0);
    chk("t3_hi", HI, 32'hFFFF_FFFF);
    chk("t3_lo", LO, 32'hFFFF_FFFD);
    issue(4'd4, 32'd7, 32'd0);
    tick();
    idle();
    for (int i = 0; i < 10; i++) begin
      chk("t3z_busy", {31'd0, E_Busy}, 32'd1);
      tick();
    end
    chk("t3z_busy_done", {31'd0, E_Busy}, 32'd0);
    chk("t3z_hi", HI, 32'hFFFF_FFFF);
    chk("t3z_lo", LO, 32'hFFFF_FFFD);

    // 4: div 100/7 with MD instruction waiting in D
    D_IsMD = 1'b1;
    issue(4'd3, 32'd100, 32'd7);
    #1;
    chk("t4_stall_issue", {31'd0, D_MDStall}, 32'd1);
    tick();
    idle();
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t4_stall", {31'd0, D_MDStall}, 32'd1);
      tick();
    end
    issue(4'd6, 32'd0, 32'd0);
    #1;
    chk("t4_stall_free", {31'd0, D_MDStall}, 32'd0);
    chk("t4_mflo", E_MDOut, 32'd14);
    chk("t4_hi", HI, 32'd2);
    tick();

    // 5: mthi / mfhi / mflo / mtlo in IDLE
    issue(4'd7, 32'h0000_1234, 32'd0);
    #1;
    chk("t5_mthi_stall", {31'd0, D_MDStall}, 32'd0);
    tick();
    issue(4'd5, 32'd0, 32'd0);
    #1;
    chk("t5_mfhi", E_MDOut, 32'h0000_1234);
    chk("t5_busy", {31'd0, E_Busy}, 32'd0);
    issue(4'd6, 32'd0, 32'd0);
    #1;
    chk("t5_mflo", E_MDOut, 32'd14);
    issue(4'd0, 32'd0, 32'd0);
    #1;
    chk("t5_none_out", E_MDOut, 32'd0);
    issue(4'd8, 32'h0000_5678, 32'd0);
    tick();
    idle();
    chk("t5_mtlo", LO, 32'h0000_5678);
    chk("t5_hi_keep", HI, 32'h0000_1234);

    // hazards: ops arriving while BUSY are ignored
    issue(4'd1, 32'd3, 32'd4);
    tick();
    issue(4'd8, 32'h0000_BEEF, 32'd0);
    #1;
    chk("hz_stall_busy", {31'd0, D_MDStall}, 32'd1);
    tick();
    issue(4'd3, 32'd100, 32'd7);
    tick();
    idle();
    tick();
    tick();
    chk("hz_busy_last", {31'd0, E_Busy}, 32'd1);
    chk("hz_lo_hold", LO, 32'h0000_5678);
    issue(4'd4, 32'd9, 32'd2);
    tick();
    idle();
    chk("hz_busy_done", {31'd0, E_Busy}, 32'd0);
    chk("hz_hi", HI, 32'd0);
    chk("hz_lo", LO, 32'd12);

    // signed overflow 0x80000000 / -1
    issue(4'd7, 32'h0000_AAAA, 32'd0);
    tick();
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    tick();
    idle();
    repeat (10) tick();
    chk("ovf_busy", {31'd0, E_Busy}, 32'd0);
    chk("ovf_hi", HI, 32'd0);
    chk("ovf_lo", LO, 32'h8000_0000);

    // 6: async reset in cycle 3 of a mult
    issue(4'd1, 32'd5, 32'd6);
    tick();
    idle();
    tick();
    tick();
    chk("t6_busy_pre", {31'd0, E_Busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_busy_rst", {31'd0, E_Busy}, 32'd0);
    chk("t6_hi_rst", HI, 32'd0);
    chk("t6_lo_rst", LO, 32'd0);
    tick();
    reset = 1'b1;
    repeat (8) tick();
    chk("t6_busy_after", {31'd0, E_Busy}, 32'd0);
    chk("t6_hi_after", HI, 32'd0);
    chk("t6_lo_after", LO, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
